alu_req_ctrl: RTL

Initiator-side controller for the 32-bit combinational ALU (A, B, F[2:0] -> R, Cout). It accepts operation commands over a valid/ready interface and drives the ALU operand and function ports. After a programmable settle time it captures R and Cout, and returns them with a Zero flag over a valid/ready response interface. It also supports chained operation, where operand A is taken from the last result. It sits between the datapath sequencer (or a testbench) and the ALU, so the ALU itself stays purely combinational.

---
 rtl/alu_req_ctrl_pkg.sv | 23 ++
 rtl/alu_req_ctrl_if.sv | 30 +++
 rtl/alu_req_ctrl_rsp.sv | 41 ++++
 rtl/alu_req_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/alu_req_ctrl_pkg.sv
// Shared definitions for the ALU request controller: datapath width,
// ALU function codes and the controller state encoding.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XNOR = 3'b100;
   localparam logic [2:0] ALU_NOTA = 3'b101;
   localparam logic [2:0] ALU_PASSA = 3'b110;
   localparam logic [2:0] ALU_NOTB = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/alu_req_ctrl_if.sv
// Command and response handshake bundle between a sequencer (master)
// and the ALU request controller (slave).
interface alu_req_ctrl_if #(
   parameter int WIDTH = 32
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_f;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_chain;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_r;
   logic             rsp_cout;
   logic             rsp_zero;

   modport master (
      output cmd_valid, cmd_f, cmd_a, cmd_b, cmd_chain, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_r, rsp_cout, rsp_zero
   );

   modport slave (
      input  cmd_valid, cmd_f, cmd_a, cmd_b, cmd_chain, rsp_ready,
      output cmd_ready, rsp_valid, rsp_r, rsp_cout, rsp_zero
   );

endinterface

// File: rtl/alu_req_ctrl_rsp.sv
// Response and chain-accumulator capture register; loads the ALU result,
// carry and zero flag in a single cycle when capture is asserted.
module alu_rsp_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic [WIDTH-1:0] r_in,
   input  logic             cout_in,
   output logic [WIDTH-1:0] rsp_r,
   output logic             rsp_cout,
   output logic             rsp_zero,
   output logic [WIDTH-1:0] acc
);

   logic [WIDTH-1:0] r_reg;
   logic             cout_reg;
   logic             zero_reg;
   logic [WIDTH-1:0] acc_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg    <= '0;
         cout_reg <= 1'b0;
         zero_reg <= 1'b1;
         acc_reg  <= '0;
      end else if (capture) begin
         r_reg    <= r_in;
         cout_reg <= cout_in;
         zero_reg <= (r_in == '0);
         acc_reg  <= r_in;
      end
   end

   assign rsp_r    = r_reg;
   assign rsp_cout = cout_reg;
   assign rsp_zero = zero_reg;
   assign acc      = acc_reg;

endmodule

// File: rtl/alu_req_ctrl.sv
// Initiator-side controller for the combinational ALU: latches a command onto
// the ALU inputs, waits the settle time, captures the result and returns it.
module alu_req_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH         = ALU_W,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   alu_req_ctrl_if.slave    bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_cout,
   output logic             busy
);

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
   logic [2:0]       alu_f_reg;
   logic [WIDTH-1:0] acc;
   logic             accept;
   logic             capture;

   assign accept  = (state_reg == ST_IDLE) && bus.cmd_valid;
   assign capture = (state_reg == ST_CAPTURE);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               state_next = ST_SETTLE;
               cnt_next   = 4'(SETTLE_CYCLES - 1);
            end
         end
         ST_SETTLE: begin
            if (cnt_reg == 4'd0) state_next = ST_CAPTURE;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         ST_CAPTURE: state_next = ST_RESP;
         // A command arriving alongside rsp_ready waits for the next IDLE cycle
         ST_RESP: begin
            if (bus.rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         alu_a_reg <= '0;
         alu_b_reg <= '0;
         alu_f_reg <= 3'b000;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            alu_a_reg <= bus.cmd_chain ? acc : bus.cmd_a;
            alu_b_reg <= bus.cmd_b;
            alu_f_reg <= bus.cmd_f;
         end
      end
   end

   alu_rsp_reg #(
      .WIDTH (WIDTH)
   ) u_rsp_reg (
      .clk      (clk),
      .rst      (rst),
      .capture  (capture),
      .r_in     (alu_r),
      .cout_in  (alu_cout),
      .rsp_r    (bus.rsp_r),
      .rsp_cout (bus.rsp_cout),
      .rsp_zero (bus.rsp_zero),
      .acc      (acc)
   );

   assign alu_a         = alu_a_reg;
   assign alu_b         = alu_b_reg;
   assign alu_f         = alu_f_reg;
   assign bus.cmd_ready = (state_reg == ST_IDLE);
   assign bus.rsp_valid = (state_reg == ST_RESP);
   assign busy          = (state_reg != ST_IDLE);

endmodule
